// File: rtl/addition_normalizer_pipe.sv
// Two-stage normaliser between mantissa addition and rounding: stage 1 captures the sum and
// its leading-zero count, stage 2 shifts, adjusts the exponent and raises overflow/underflow/zero.
module addition_normalizer_pipe #(
  parameter int MENT_WIDTH = 23,
  parameter int EXPO_WIDTH = 8
) (
  input  logic                  clk_in,
  input  logic                  rst_n_in,
  input  logic                  valid_in,
  output logic                  ready_in,
  input  logic                  sign_in,
  input  logic [EXPO_WIDTH-1:0] bigger_exponent_in,
  input  logic [MENT_WIDTH+4:0] sum_in,
  output logic                  valid_out,
  input  logic                  ready_out,
  output logic                  sign_out,
  output logic [MENT_WIDTH-1:0] normalized_mentissa_out,
  output logic [EXPO_WIDTH-1:0] normalized_exponent_out,
  output logic [2:0]            grs_out,
  output logic                  overflow_out,
  output logic                  underflow_out,
  output logic                  zero_out
);

  localparam int SUM_W = MENT_WIDTH + 5;
  localparam int LZC_W = $clog2(SUM_W);

  typedef struct packed {
    logic [MENT_WIDTH-1:0] mant;
    logic [EXPO_WIDTH-1:0] expo;
    logic [2:0]            grs;
    logic                  ovf;
    logic                  unf;
    logic                  zero;
  } norm_t;

  // Zeros counted from the hidden-bit position down; an all-zero vector gives SUM_W-1.
  function automatic logic [LZC_W-1:0] count_lz(input logic [SUM_W-1:0] sum);
    logic [LZC_W-1:0] n;
    logic             found;
    n     = '0;
    found = 1'b0;
    for (int i = SUM_W - 2; i >= 0; i--) begin
      if (!found) begin
        if (sum[i]) found = 1'b1;
        else        n = n + LZC_W'(1);
      end
    end
    return n;
  endfunction

  function automatic norm_t normalize(input logic [EXPO_WIDTH-1:0] expo,
                                      input logic [SUM_W-1:0]      sum,
                                      input logic                  carry,
                                      input logic [LZC_W-1:0]      lzc);
    norm_t                 r;
    logic [SUM_W-1:0]      sh;
    logic [EXPO_WIDTH-1:0] e_inc;
    r     = '0;
    sh    = '0;
    e_inc = expo + EXPO_WIDTH'(1);
    if (&expo) begin
      // Inf/NaN operand: fraction payload passes untouched.
      r.expo = expo;
      r.mant = sum[SUM_W-3:3];
    end else if (carry) begin
      if (&e_inc) begin
        r.ovf  = 1'b1;
        r.expo = '1;
      end else begin
        sh     = sum >> 1;
        r.mant = sh[SUM_W-3:3];
        r.expo = e_inc;
        r.grs  = {sum[3], sum[2], sum[1] | sum[0]};
      end
    end else if (sum == '0) begin
      r.zero = 1'b1;
    end else if (32'(expo) <= 32'(lzc)) begin
      // No subnormals: anything that would need one is flushed.
      r.unf = 1'b1;
    end else begin
      sh     = sum << lzc;
      r.mant = sh[SUM_W-3:3];
      r.grs  = sh[2:0];
      r.expo = expo - EXPO_WIDTH'(lzc);
    end
    return r;
  endfunction

  logic                  w_en1;
  logic                  w_en2;
  logic [LZC_W-1:0]      w_lzc;
  norm_t                 w_norm;

  logic                  r_vld_p1;
  logic                  r_sign_p1;
  logic [EXPO_WIDTH-1:0] r_exp_p1;
  logic [SUM_W-1:0]      r_sum_p1;
  logic                  r_carry_p1;
  logic [LZC_W-1:0]      r_lzc_p1;

  logic                  r_vld_p2;
  logic                  r_sign_p2;
  logic [MENT_WIDTH-1:0] r_mant_p2;
  logic [EXPO_WIDTH-1:0] r_exp_p2;
  logic [2:0]            r_grs_p2;
  logic                  r_ovf_p2;
  logic                  r_unf_p2;
  logic                  r_zero_p2;

  assign w_en2    = ~r_vld_p2 | ready_out;
  assign w_en1    = ~r_vld_p1 | w_en2;
  assign ready_in = w_en1;
  assign w_lzc    = count_lz(sum_in);
  assign w_norm   = normalize(r_exp_p1, r_sum_p1, r_carry_p1, r_lzc_p1);

  // Stage 1: capture beat and leading-zero count
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_vld_p1   <= 1'b0;
      r_sign_p1  <= 1'b0;
      r_exp_p1   <= '0;
      r_sum_p1   <= '0;
      r_carry_p1 <= 1'b0;
      r_lzc_p1   <= '0;
    end else if (w_en1) begin
      r_vld_p1 <= valid_in;
      if (valid_in) begin
        r_sign_p1  <= sign_in;
        r_exp_p1   <= bigger_exponent_in;
        r_sum_p1   <= sum_in;
        r_carry_p1 <= sum_in[SUM_W-1];
        r_lzc_p1   <= w_lzc;
      end
    end
  end

  // Stage 2: shifted mantissa, adjusted exponent and flags
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_vld_p2  <= 1'b0;
      r_sign_p2 <= 1'b0;
      r_mant_p2 <= '0;
      r_exp_p2  <= '0;
      r_grs_p2  <= '0;
      r_ovf_p2  <= 1'b0;
      r_unf_p2  <= 1'b0;
      r_zero_p2 <= 1'b0;
    end else if (w_en2) begin
      r_vld_p2 <= r_vld_p1;
      if (r_vld_p1) begin
        r_sign_p2 <= r_sign_p1;
        r_mant_p2 <= w_norm.mant;
        r_exp_p2  <= w_norm.expo;
        r_grs_p2  <= w_norm.grs;
        r_ovf_p2  <= w_norm.ovf;
        r_unf_p2  <= w_norm.unf;
        r_zero_p2 <= w_norm.zero;
      end
    end
  end

  assign valid_out               = r_vld_p2;
  assign sign_out                = r_sign_p2;
  assign normalized_mentissa_out = r_mant_p2;
  assign normalized_exponent_out = r_exp_p2;
  assign grs_out                 = r_grs_p2;
  assign overflow_out            = r_ovf_p2;
  assign underflow_out           = r_unf_p2;
  assign zero_out                = r_zero_p2;

endmodule

// File: tb/tb_addition_normalizer_pipe.sv
// Directed-vector bench for addition_normalizer_pipe (MENT_WIDTH=23, EXPO_WIDTH=8).
module tb_addition_normalizer_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid_in;
  logic        ready_in;
  logic        sign_in;
  logic [7:0]  bigger_exponent_in;
  logic [27:0] sum_in;
  logic        valid_out;
  logic        ready_out;
  logic        sign_out;
  logic [22:0] mant_out;
  logic [7:0]  exp_out;
  logic [2:0]  grs_out;
  logic        ovf_out;
  logic        unf_out;
  logic        zero_out;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  addition_normalizer_pipe #(.MENT_WIDTH(23), .EXPO_WIDTH(8)) dut (
    .clk_in                 (clk),
    .rst_n_in               (rst_n),
    .valid_in               (valid_in),
    .ready_in               (ready_in),
    .sign_in                (sign_in),
    .bigger_exponent_in     (bigger_exponent_in),
    .sum_in                 (sum_in),
    .valid_out              (valid_out),
    .ready_out              (ready_out),
    .sign_out               (sign_out),
    .normalized_mentissa_out(mant_out),
    .normalized_exponent_out(exp_out),
    .grs_out                (grs_out),
    .overflow_out           (ovf_out),
    .underflow_out          (unf_out),
    .zero_out               (zero_out)
  );

  // Output bundle: {sign, mant, exp, grs, ovf, unf, zero} = 38 bits
  typedef struct {
    string       name;
    logic        s;
    logic [7:0]  e;
    logic [27:0] sum;
    logic [37:0] want;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [37:0] mk(logic s, logic [22:0] m, logic [7:0] e, logic [2:0] g,
                                     logic ov, logic un, logic z);
    return {s, m, e, g, ov, un, z};
  endfunction

  function automatic logic [37:0] got();
    return {sign_out, mant_out, exp_out, grs_out, ovf_out, unf_out, zero_out};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input vec_t v);
    sign_in            = v.s;
    bigger_exponent_in = v.e;
    sum_in             = v.sum;
  endtask

  task automatic add(input string n, input logic s, input logic [7:0] e, input logic [27:0] sum,
                     input logic [37:0] w);
    vec_t v;
    v.name = n; v.s = s; v.e = e; v.sum = sum; v.want = w;
    vecs.push_back(v);
  endtask

  initial begin
    add("carry",        1'b0, 8'd127, 28'h8000000, mk(0, 23'h0,      8'd128, 3'b000, 0, 0, 0));
    add("cancel",       1'b1, 8'd100, 28'h0000008, mk(1, 23'h0,      8'd77,  3'b000, 0, 0, 0));
    add("underflow",    1'b0, 8'd10,  28'h0000008, mk(0, 23'h0,      8'd0,   3'b000, 0, 1, 0));
    add("overflow",     1'b0, 8'd254, 28'h8000000, mk(0, 23'h0,      8'hFF,  3'b000, 1, 0, 0));
    add("zero",         1'b1, 8'd50,  28'h0000000, mk(1, 23'h0,      8'd0,   3'b000, 0, 0, 1));
    add("special",      1'b0, 8'hFF,  28'h5ABCDEF, mk(0, 23'h3579BD, 8'hFF,  3'b000, 0, 0, 0));
    add("no_shift",     1'b0, 8'd60,  28'h4000005, mk(0, 23'h0,      8'd60,  3'b101, 0, 0, 0));
    add("carry_grs",    1'b1, 8'd20,  28'hC00000F, mk(1, 23'h400000, 8'd21,  3'b111, 0, 0, 0));
    add("shift1",       1'b0, 8'd5,   28'h2000003, mk(0, 23'h0,      8'd4,   3'b110, 0, 0, 0));
    add("unf_edge",     1'b0, 8'd23,  28'h0000008, mk(0, 23'h0,      8'd0,   3'b000, 0, 1, 0));
    add("unf_edge_p1",  1'b0, 8'd24,  28'h0000008, mk(0, 23'h0,      8'd1,   3'b000, 0, 0, 0));
    add("carry_to_254", 1'b0, 8'd253, 28'h8000000, mk(0, 23'h0,      8'd254, 3'b000, 0, 0, 0));
    add("shift6",       1'b0, 8'd100, 28'h0123456, mk(0, 23'h11A2B0, 8'd94,  3'b000, 0, 0, 0));

    rst_n = 1'b0; valid_in = 1'b0; ready_out = 1'b1;
    sign_in = 1'b0; bigger_exponent_in = '0; sum_in = '0;
    #12;
    chk("reset_valid_out", {63'd0, valid_out}, 64'd0);
    chk("reset_outputs", {26'd0, got()}, 64'd0);
    rst_n = 1'b1;
    step();
    chk("reset_ready_in", {63'd0, ready_in}, 64'd1);

    // Single beats, two-cycle latency each
    foreach (vecs[i]) begin
      drive(vecs[i]);
      valid_in = 1'b1;
      step();
      valid_in = 1'b0;
      step();
      chk({vecs[i].name, "_valid"}, {63'd0, valid_out}, 64'd1);
      chk(vecs[i].name, {26'd0, got()}, {26'd0, vecs[i].want});
      step();
    end
    chk("drain_valid", {63'd0, valid_out}, 64'd0);

    // Backpressure: 4 beats with ready_out low for the first 6 cycles
    begin
      int sent = 0;
      int recv = 0;
      for (int c = 0; c < 40 && recv < 4; c++) begin
        ready_out = (c >= 6);
        if (sent < 4) begin
          drive(vecs[sent]);
          valid_in = 1'b1;
        end else begin
          valid_in = 1'b0;
        end
        #1;
        if (c == 3) chk("bp_ready_in_low", {63'd0, ready_in}, 64'd0);
        if (valid_out && ready_out) begin
          chk({"bp_order_", vecs[recv].name}, {26'd0, got()}, {26'd0, vecs[recv].want});
          recv++;
        end else if (valid_out) begin
          chk("bp_stall_hold", {26'd0, got()}, {26'd0, vecs[recv].want});
        end
        if (valid_in && ready_in) sent++;
        step();
      end
      valid_in = 1'b0;
      chk("bp_beats_out", 64'(recv), 64'd4);
      step();
      chk("bp_no_extra", {63'd0, valid_out}, 64'd0);
    end

    // Reset with two beats in flight
    ready_out = 1'b0;
    for (int i = 0; i < 2; i++) begin
      drive(vecs[7 + i]);
      valid_in = 1'b1;
      step();
    end
    valid_in = 1'b0;
    chk("rst_pre_valid", {63'd0, valid_out}, 64'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_valid", {63'd0, valid_out}, 64'd0);
    chk("rst_mid_outputs", {26'd0, got()}, 64'd0);
    step();
    rst_n = 1'b1;
    ready_out = 1'b1;
    #1;
    chk("rst_ready_in", {63'd0, ready_in}, 64'd1);
    for (int c = 0; c < 4; c++) begin
      step();
      chk("rst_nothing_out", {63'd0, valid_out}, 64'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
